// File: rtl/exam2_2.sv
// exam2_2 -- serial Moore sequence detector for the pattern 0,0,1,1 (oldest first).
// One bit of X is sampled per rising clk edge; Y pulses high for exactly one clock
// period after the edge that samples the final 1. Overlapping matches are detected.
//
// Ports:
//   clk    input   system clock, rising-edge active
//   rst_n  input   asynchronous reset, active-low (state -> S0, Y -> 0)
//   X      input   serial data bit, sampled on each rising clk edge
//   Y      output  registered match flag, high while the FSM is in S4
module exam2_2 (
  input  logic clk,
  input  logic rst_n,
  input  logic X,
  output logic Y
);

  // Prefix-tracking states; 5..7 are unused and recover to S0.
  typedef enum logic [2:0] {
    S0 = 3'd0,  // no useful prefix
    S1 = 3'd1,  // "0"
    S2 = 3'd2,  // "00"
    S3 = 3'd3,  // "001"
    S4 = 3'd4   // "0011" match
  } state_t;

  state_t r_state;
  state_t w_next_state;
  logic   r_y;

  // Next-state logic
  always_comb begin
    w_next_state = S0;
    case (r_state)
      S0:      w_next_state = X ? S0 : S1;
      S1:      w_next_state = X ? S0 : S2;
      S2:      w_next_state = X ? S3 : S2;
      S3:      w_next_state = X ? S4 : S1;
      // Trailing 0 of a match only counts as a fresh single "0".
      S4:      w_next_state = X ? S0 : S1;
      default: w_next_state = S0;
    endcase
  end

  // State register plus a dedicated Y flop loaded from the next state, so Y
  // mirrors (state == S4) without any combinational path from X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S0;
      r_y     <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_y     <= (w_next_state == S4);
    end
  end

  assign Y = r_y;

endmodule

// File: tb/tb_exam2_2.sv
// Bench for exam2_2: directed scenarios plus random serial data, checked against
// a model that remembers the last four sampled bits since reset and expects Y
// whenever they read 0,0,1,1.
module tb_exam2_2;

  logic clk;
  logic rst_n;
  logic X;
  logic Y;

  int unsigned n_checks;
  int unsigned n_fail;

  // Reference model: history of sampled bits (newest in bit 0) and count since reset.
  logic [3:0]  m_hist;
  int unsigned m_cnt;

  exam2_2 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .X     (X),
    .Y     (Y)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed Y=%b expected Y=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic model_y();
    return (m_cnt >= 4) && (m_hist == 4'b0011);
  endfunction

  // Entered just after a falling edge: present X, let the rising edge sample it,
  // check Y shortly after, then return at the next falling edge.
  task automatic drive_bit(input logic b, input string tag);
    X = b;
    @(posedge clk);
    m_hist = {m_hist[2:0], b};
    m_cnt++;
    #1;
    check(tag, Y, model_y());
    @(negedge clk);
  endtask

  // Short asynchronous reset pulse entirely inside the low clock phase.
  task automatic reset_pulse(input string tag);
    #2 rst_n = 1'b0;
    #1;
    m_cnt  = 0;
    m_hist = 4'b0000;
    check(tag, Y, 1'b0);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    logic [12:0] near_miss;
    n_checks = 0;
    n_fail   = 0;
    m_hist   = 4'b0000;
    m_cnt    = 0;
    rst_n    = 1'b0;
    X        = 1'b0;

    // Reset at t=0 with no clock edge yet, then held across an edge.
    #5;
    check("reset_no_edge", Y, 1'b0);
    @(posedge clk);
    #1;
    check("reset_held_edge", Y, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Square wave: X toggles every 100 ns (five clock periods), starting low.
    for (int p = 0; p < 4; p++)
      for (int i = 0; i < 10; i++)
        drive_bit(i >= 5, "square_wave");

    // Overlapping matches: 0,0,1,1,0,0,1,1 from a clean start.
    reset_pulse("reset_before_overlap");
    for (int i = 0; i < 8; i++)
      drive_bit(i[1], "overlap");
    // Async reset while Y is high must clear it immediately.
    check("overlap_pulse_present", Y, 1'b1);
    reset_pulse("reset_clears_pulse");

    // Near-misses: 0,1,1,0,1,1,1,0,0,0,1,0,1 never match.
    near_miss = 13'b0110111000101;
    for (int i = 12; i >= 0; i--)
      drive_bit(near_miss[i], "near_miss");

    // Long zero run followed by 1,1,1: one pulse only.
    for (int i = 0; i < 10; i++) drive_bit(1'b0, "zero_run");
    for (int i = 0; i < 3; i++)  drive_bit(1'b1, "zero_run_ones");

    // Mid-sequence reset discards the "001" prefix.
    drive_bit(1'b0, "mid_reset_pre");
    drive_bit(1'b0, "mid_reset_pre");
    drive_bit(1'b1, "mid_reset_pre");
    reset_pulse("mid_reset_async");
    drive_bit(1'b1, "mid_reset_no_pulse");
    drive_bit(1'b0, "mid_reset_fresh");
    drive_bit(1'b0, "mid_reset_fresh");
    drive_bit(1'b1, "mid_reset_fresh");
    drive_bit(1'b1, "mid_reset_fresh");
    check("mid_reset_fresh_pulse", Y, 1'b1);

    // Random serial data, biased toward zeros so matches are frequent.
    for (int i = 0; i < 400; i++)
      drive_bit(($urandom_range(0, 99) < 55) ? 1'b0 : 1'b1, "random");

    // Random data with occasional asynchronous resets.
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 24) == 0) reset_pulse("random_reset");
      drive_bit(($urandom_range(0, 99) < 55) ? 1'b0 : 1'b1, "random_rst_mix");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
